// File: rtl/maxpool2_mem_engine_if.sv
// Memory request bus shared by the pooling engine and the word memory.
// The bidirectional data lines stay a direct port of the engine so that
// their high-Z resolution lives with the net that owns them.
interface maxpool2_mem_engine_if #(
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic                  mem_w;
  logic                  mem_sel;
  logic [ADDR_WIDTH-1:0] address_bus;
  logic                  ready;

  modport master (
    output mem_w,
    output mem_sel,
    output address_bus,
    input  ready
  );

  modport slave (
    input  mem_w,
    input  mem_sel,
    input  address_bus,
    output ready
  );
endinterface

// File: rtl/maxpool2_mem_engine.sv
// Max-pooling engine: reads a HEIGHT x WIDTH map from word memory, pools
// POOL_SIZE x POOL_SIZE windows with step STRIDE, and writes the pooled map
// back one word per output element.
module maxpool2_mem_engine #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATABUS_WIDTH = 32,
  parameter int unsigned HEIGHT        = 4,
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned POOL_SIZE     = 2,
  parameter int unsigned STRIDE        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     done,
  input  logic [ADDR_WIDTH-1:0]    input_addr,
  input  logic [ADDR_WIDTH-1:0]    output_addr,
  maxpool2_mem_engine_if.master    bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus
);

  localparam int unsigned OH      = (HEIGHT - POOL_SIZE) / STRIDE + 1;
  localparam int unsigned OW      = (WIDTH - POOL_SIZE) / STRIDE + 1;
  localparam int unsigned DIM_MAX = (HEIGHT > WIDTH) ? HEIGHT : WIDTH;
  localparam int unsigned CW      = ($clog2(DIM_MAX) < 1) ? 1 : $clog2(DIM_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] in_base, out_base;
  logic [CW-1:0]         oy, ox, py, px;
  logic [DATA_WIDTH-1:0] run_max;
  logic [DATA_WIDTH-1:0] rd_elem;
  logic                  gap;
  logic                  sel, wr;
  logic                  last_px, last_py, last_ox, last_oy;
  logic [31:0]           rd_row;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr, addr;
  logic                  unused_bus;

  assign rd_elem    = data_bus[DATA_WIDTH-1:0];
  assign unused_bus = ^data_bus;

  assign last_px = (px == CW'(POOL_SIZE - 1));
  assign last_py = (py == CW'(POOL_SIZE - 1));
  assign last_ox = (ox == CW'(OW - 1));
  assign last_oy = (oy == CW'(OH - 1));

  // Element addresses for the current window position and output slot.
  always_comb begin
    rd_row  = 32'(oy) * STRIDE + 32'(py);
    rd_addr = in_base + ADDR_WIDTH'(rd_row * WIDTH + 32'(ox) * STRIDE + 32'(px));
    wr_addr = out_base + ADDR_WIDTH'(32'(oy) * OW + 32'(ox));
    addr    = '0;
    if (state == RD_REQ || state == RD_WAIT) begin
      addr = rd_addr;
    end else if (state == WR_REQ || state == WR_WAIT) begin
      addr = wr_addr;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and bus strobes. A REQ state entered straight after a
  // completed transaction spends one cycle with mem_sel low (gap) so the
  // memory sees a fresh request edge every time.
  always_comb begin
    state_next = state;
    sel        = 1'b0;
    wr         = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RD_REQ;
      end
      RD_REQ: begin
        sel = !gap;
        if (!gap) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        sel = 1'b1;
        if (bus.ready) state_next = (last_px && last_py) ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        sel = !gap;
        wr  = !gap;
        if (!gap) state_next = WR_WAIT;
      end
      WR_WAIT: begin
        sel = 1'b1;
        wr  = 1'b1;
        if (bus.ready) state_next = (last_ox && last_oy) ? DONE : RD_REQ;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = RD_REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_sel     = sel;
  assign bus.mem_w       = wr;
  assign bus.address_bus = addr;
  assign data_bus        = (sel && wr) ? DATABUS_WIDTH'(run_max) : 'z;

  // Bases, window/output counters and the running maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap      <= 1'b0;
      in_base  <= '0;
      out_base <= '0;
      oy       <= '0;
      ox       <= '0;
      py       <= '0;
      px       <= '0;
      run_max  <= '0;
    end else begin
      gap <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            in_base  <= input_addr;
            out_base <= output_addr;
            oy       <= '0;
            ox       <= '0;
            py       <= '0;
            px       <= '0;
          end
        end
        RD_WAIT: begin
          if (bus.ready) begin
            gap <= 1'b1;
            if ((py == '0 && px == '0) || rd_elem > run_max) run_max <= rd_elem;
            if (last_px) begin
              px <= '0;
              if (last_py) py <= '0;
              else         py <= py + CW'(1);
            end else begin
              px <= px + CW'(1);
            end
          end
        end
        WR_WAIT: begin
          if (bus.ready) begin
            gap <= 1'b1;
            if (last_ox) begin
              ox <= '0;
              if (!last_oy) oy <= oy + CW'(1);
            end else begin
              ox <= ox + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2_mem_engine.sv
// Bench for maxpool2_mem_engine: word-memory model, write scoreboard and
// bus-protocol monitor around the default 4x4 / 2x2 / stride-2 engine.
module tb_maxpool2_mem_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [7:0]  input_addr = '0;
  logic [7:0]  output_addr = '0;
  wire  [31:0] data_bus;
  logic        load_en = 1'b0;

  logic [31:0] memory [0:255];
  logic [31:0] image  [0:255];

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  int checks = 0;
  int failures = 0;
  int rd_strobes = 0, wr_strobes = 0, rd_done = 0, wr_done = 0;
  int base_rd = 0, base_wr = 0;

  maxpool2_mem_engine_if #(.ADDR_WIDTH(8)) bus ();

  maxpool2_mem_engine #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .DATABUS_WIDTH(32),
    .HEIGHT(4), .WIDTH(4), .POOL_SIZE(2), .STRIDE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .done(done),
    .input_addr(input_addr),
    .output_addr(output_addr),
    .bus(bus),
    .data_bus(data_bus)
  );

  always #5 clk = ~clk;

  // Word memory: ready one cycle after a request is first seen.
  always @(posedge clk) begin
    if (rst) begin
      bus.ready <= 1'b0;
    end else begin
      bus.ready <= bus.mem_sel && !bus.ready;
      if (bus.mem_sel && bus.mem_w && bus.ready) memory[bus.address_bus] <= data_bus;
      if (load_en) memory <= image;
    end
  end
  assign data_bus = (bus.mem_sel && !bus.mem_w && bus.ready) ? memory[bus.address_bus] : 'z;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pool_at(input logic [7:0] in_b, input int oy, input int ox);
    logic [7:0] m = 8'd0;
    logic [7:0] a;
    logic [7:0] v;
    for (int py = 0; py < 2; py++) begin
      for (int px = 0; px < 2; px++) begin
        a = in_b + 8'((oy * 2 + py) * 4 + ox * 2 + px);
        v = image[a][7:0];
        if (v > m) m = v;
      end
    end
    return m;
  endfunction

  // Protocol monitor and write scoreboard.
  task automatic monitor();
    logic       p_sel = 1'b0, p_rdy = 1'b0, p_w = 1'b0;
    logic [7:0] p_addr = '0;
    wr_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_sel = 1'b0;
        p_rdy = 1'b0;
      end else begin
        if (bus.mem_sel && !p_sel) begin
          if (bus.mem_w) wr_strobes++;
          else           rd_strobes++;
        end
        if (p_sel && !p_rdy) begin
          check_eq("hold_sel", 32'(bus.mem_sel), 32'd1);
          check_eq("hold_addr", 32'(bus.address_bus), 32'(p_addr));
          check_eq("hold_w", 32'(bus.mem_w), 32'(p_w));
        end
        if (p_sel && p_rdy) check_eq("sel_gap", 32'(bus.mem_sel), 32'd0);
        if (bus.mem_sel && bus.ready) begin
          if (bus.mem_w) begin
            wr_done++;
            if (sb.size() == 0) begin
              check_eq("wr_unexpected", 32'(bus.address_bus), 32'hFFFF_FFFF);
            end else begin
              e = sb.pop_front();
              check_eq("wr_addr", 32'(bus.address_bus), 32'(e.addr));
              check_eq("wr_data", data_bus, e.data);
              image[e.addr] = e.data;
            end
          end else begin
            rd_done++;
            check_eq("rd_bus", data_bus, memory[bus.address_bus]);
          end
        end
        p_sel  = bus.mem_sel;
        p_rdy  = bus.ready;
        p_w    = bus.mem_w;
        p_addr = bus.address_bus;
      end
    end
  endtask

  task automatic load_memory();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic launch(input logic [7:0] in_b, input logic [7:0] out_b);
    wr_t e;
    for (int oy = 0; oy < 2; oy++) begin
      for (int ox = 0; ox < 2; ox++) begin
        e.addr = out_b + 8'(oy * 2 + ox);
        e.data = {24'h0, pool_at(in_b, oy, ox)};
        sb.push_back(e);
      end
    end
    base_rd = rd_strobes;
    base_wr = wr_strobes;
    @(negedge clk);
    input_addr  = in_b;
    output_addr = out_b;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_clear", 32'(done), 32'd0);
  endtask

  task automatic check_memory(input string tag);
    for (int i = 0; i < 256; i++) begin
      check_eq($sformatf("%s_mem[%0d]", tag, i), memory[i], image[i]);
    end
  endtask

  task automatic run_done(input string tag);
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check_eq({tag, "_rd_strobes"}, 32'(rd_strobes - base_rd), 32'd16);
    check_eq({tag, "_wr_strobes"}, 32'(wr_strobes - base_wr), 32'd4);
    @(negedge clk);
    check_memory(tag);
  endtask

  initial begin
    int n;
    int rbase;
    int wbase;
    fork
      monitor();
    join_none

    for (int i = 0; i < 256; i++) image[i] = 32'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_sel", 32'(bus.mem_sel), 32'd0);
    check_eq("rst_w", 32'(bus.mem_w), 32'd0);
    check_eq("rst_addr", 32'(bus.address_bus), 32'd0);
    rst = 1'b0;

    // Basic ascending map
    for (int i = 0; i < 16; i++) image[i] = 32'(i + 1);
    for (int i = 20; i < 24; i++) image[i] = 32'hFFFF_FFFF;
    image[24] = 32'hDEAD_BEEF;
    load_memory();
    launch(8'd0, 8'd20);
    run_done("basic");
    check_eq("basic_o0", memory[20], 32'd6);
    check_eq("basic_o1", memory[21], 32'd8);
    check_eq("basic_o2", memory[22], 32'd14);
    check_eq("basic_o3", memory[23], 32'd16);
    check_eq("basic_m24", memory[24], 32'hDEAD_BEEF);

    // Descending map: max at the first window element
    for (int i = 0; i < 16; i++) image[i] = 32'(16 - i);
    load_memory();
    launch(8'd0, 8'd20);
    run_done("desc");
    check_eq("desc_o0", memory[20], 32'd16);
    check_eq("desc_o1", memory[21], 32'd14);
    check_eq("desc_o2", memory[22], 32'd8);
    check_eq("desc_o3", memory[23], 32'd6);

    // Max at a different window position in each window
    for (int i = 0; i < 16; i++) image[i] = 32'd1;
    image[0] = 32'd21; image[3] = 32'd22; image[12] = 32'd23; image[15] = 32'd24;
    load_memory();
    launch(8'd0, 8'd20);
    run_done("pos");
    check_eq("pos_o0", memory[20], 32'd21);
    check_eq("pos_o1", memory[21], 32'd22);
    check_eq("pos_o2", memory[22], 32'd23);
    check_eq("pos_o3", memory[23], 32'd24);

    // Extremes and unsigned compare; upper word bits must be ignored
    image[0] = 32'hAB00_00FF; image[1] = 32'h0000_00FF; image[4] = 32'h1200_00FF; image[5] = 32'h0000_00FF;
    image[2] = 32'hFF00_0000; image[3] = 32'h0;         image[6] = 32'h0000_FF00; image[7] = 32'h0;
    image[8] = 32'h7F;        image[9] = 32'h7F;        image[12] = 32'h80;       image[13] = 32'h7F;
    image[10] = 32'h01;       image[11] = 32'h81;       image[14] = 32'h7E;       image[15] = 32'h10;
    load_memory();
    launch(8'd0, 8'd20);
    run_done("ext");
    check_eq("ext_o0", memory[20], 32'hFF);
    check_eq("ext_o1", memory[21], 32'h00);
    check_eq("ext_o2", memory[22], 32'h80);
    check_eq("ext_o3", memory[23], 32'h81);

    // Start while busy is ignored; restart from DONE to a new output base
    for (int i = 0; i < 16; i++) image[i] = 32'(i + 1);
    for (int i = 100; i < 116; i++) image[i] = 32'd200;
    load_memory();
    launch(8'd0, 8'd20);
    rbase = rd_done;
    n = 0;
    while (rd_done - rbase < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_reads_seen", 32'(rd_done - rbase >= 5), 32'd1);
    input_addr  = 8'd100;
    output_addr = 8'd60;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_done("busy");
    check_eq("busy_o3", memory[23], 32'd16);
    check_eq("busy_m60", memory[60], 32'd0);
    launch(8'd0, 8'd40);
    run_done("restart");
    check_eq("restart_o0", memory[40], 32'd6);
    check_eq("restart_o3", memory[43], 32'd16);

    // Reset after the sixth read
    for (int i = 20; i < 24; i++) image[i] = 32'h5555_5555;
    load_memory();
    launch(8'd0, 8'd20);
    rbase = rd_done;
    n = 0;
    while (rd_done - rbase < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst6_reads_seen", 32'(rd_done - rbase >= 6), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst6_done", 32'(done), 32'd0);
    check_eq("rst6_sel", 32'(bus.mem_sel), 32'd0);
    check_eq("rst6_w", 32'(bus.mem_w), 32'd0);
    rst = 1'b0;
    sb.delete();
    wbase = wr_done;
    repeat (10) @(negedge clk);
    check_eq("rst6_no_write", 32'(wr_done - wbase), 32'd0);
    check_eq("rst6_idle_sel", 32'(bus.mem_sel), 32'd0);
    check_eq("rst6_o1_kept", memory[21], 32'h5555_5555);
    check_memory("rst6");
    launch(8'd0, 8'd20);
    run_done("after_rst");
    check_eq("after_rst_o1", memory[21], 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
